// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared types, JA command codes, VGA timing and helper functions for the bomberman core
package bomberman_pkg;

    localparam int GRID = 8;

    typedef logic [2:0] coord_t;
    typedef logic [3:0] health_t;

    // Player B command nibble (JA[7:4])
    localparam logic [3:0] JA_IDLE  = 4'b0001;
    localparam logic [3:0] JA_UP    = 4'b0010;
    localparam logic [3:0] JA_DOWN  = 4'b0011;
    localparam logic [3:0] JA_LEFT  = 4'b0100;
    localparam logic [3:0] JA_RIGHT = 4'b0101;
    localparam logic [3:0] JA_BOMB  = 4'b1011;

    // Bit positions of player A's buttons in the debounced vector
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_S = 4;

    // 640x480 timing in pixel counts
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;

    typedef enum logic [2:0] {
        ACT_NONE, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT, ACT_BOMB
    } act_t;

    typedef enum logic {
        ST_PLAY, ST_OVER
    } game_state_t;

    typedef struct packed {
        logic   ok;
        coord_t x;
        coord_t y;
    } cell_t;

    function automatic logic is_pillar(input coord_t x, input coord_t y);
        return x[0] & y[0];
    endfunction

    // Target cell of a move; ok=0 when the step would leave the grid or is not a move
    function automatic cell_t step(input coord_t x, input coord_t y, input act_t act);
        cell_t c;
        c.ok = 1'b1;
        c.x  = x;
        c.y  = y;
        case (act)
            ACT_UP:    begin c.ok = (y != 3'd0);           c.y = y - 3'd1; end
            ACT_DOWN:  begin c.ok = (y != 3'(GRID - 1));   c.y = y + 3'd1; end
            ACT_LEFT:  begin c.ok = (x != 3'd0);           c.x = x - 3'd1; end
            ACT_RIGHT: begin c.ok = (x != 3'(GRID - 1));   c.x = x + 3'd1; end
            default:   c.ok = 1'b0;
        endcase
        return c;
    endfunction

    // Manhattan distance <= 1: bomb cell plus its four orthogonal neighbours
    function automatic logic in_blast(input coord_t bx, input coord_t by,
                                      input coord_t px, input coord_t py);
        logic [3:0] dx;
        logic [3:0] dy;
        dx = (bx > px) ? {1'b0, bx - px} : {1'b0, px - bx};
        dy = (by > py) ? {1'b0, by - py} : {1'b0, py - by};
        return (dx + dy) <= 4'd1;
    endfunction

    function automatic act_t ja_decode(input logic [3:0] code);
        case (code)
            JA_UP:    return ACT_UP;
            JA_DOWN:  return ACT_DOWN;
            JA_LEFT:  return ACT_LEFT;
            JA_RIGHT: return ACT_RIGHT;
            JA_BOMB:  return ACT_BOMB;
            JA_IDLE:  return ACT_NONE;
            default:  return ACT_NONE;
        endcase
    endfunction

    // Active-low {dp,g,f,e,d,c,b,a}, dp off
    function automatic logic [7:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;
            4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;
            4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;
            4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;
            4'hE: return 8'h86;  4'hF: return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/bomberman_debouncer.sv
// rtl/bomberman_debouncer.sv - 2-FF synchroniser plus stable-time debouncer for a vector of inputs
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous clear of the debounced state (game restart)
//   raw         asynchronous inputs
//   level       debounced level, adopted after DEBOUNCE stable cycles
//   toggled     bits of level that changed in the last cycle (one-cycle pulse)
module bomberman_debouncer #(
    parameter int WIDTH    = 1,
    parameter int DEBOUNCE = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] toggled
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [WIDTH-1:0] sync1, sync2, sync_prev;
    logic [WIDTH-1:0] level_q;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // The whole vector is treated as one value: any change restarts the
    // stability window, so a multi-bit command is adopted atomically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= '0;
            level_q <= '0;
            cnt     <= '0;
        end else if (clear) begin
            level   <= '0;
            level_q <= '0;
            cnt     <= '0;
        end else begin
            level_q <= level;
            if (sync2 != sync_prev || sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign toggled = level ^ level_q;

endmodule

// File: rtl/bomberman.sv
// rtl/bomberman.sv - two-player 8x8 bomberman game core with seven-segment health display and VGA sync
// Ports:
//   clk, rst_n           100 MHz clock, asynchronous active-low reset
//   sw[7]                synchronous game restart (held = held in start state)
//   btnU/D/L/R/S         player A move up/down/left/right, drop bomb
//   JA[7:4]              player B command nibble
//   seg, an              active-low seven-segment segments {dp,g..a} and digit enables
//   hsync, vsync         active-low 640x480 VGA sync
module bomberman
    import bomberman_pkg::*;
#(
    parameter int BOMB_PERIOD = 10000,
    parameter int FUSE_UNITS  = 2,
    parameter int DEBOUNCE    = 1000,
    parameter int HEALTH_INIT = 3,
    parameter int REFRESH     = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnS,
    input  logic [7:0] JA,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       hsync,
    output logic       vsync
);

    localparam int FUSE_CYCLES = FUSE_UNITS * BOMB_PERIOD;
    localparam int FW          = $clog2(FUSE_CYCLES + 1);
    localparam int RW          = $clog2(REFRESH + 1);

    logic restart;
    assign restart = sw[7];

    logic unused_inputs;
    assign unused_inputs = ^{sw[6:0], JA[3:0]};

    // ---------------- input conditioning ----------------
    logic [4:0] btn_level, btn_toggled, btn_rise;
    logic [3:0] ja_level, ja_toggled;

    bomberman_debouncer #(.WIDTH(5), .DEBOUNCE(DEBOUNCE)) u_btn_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (restart),
        .raw     ({btnS, btnR, btnL, btnD, btnU}),
        .level   (btn_level),
        .toggled (btn_toggled)
    );

    bomberman_debouncer #(.WIDTH(4), .DEBOUNCE(DEBOUNCE)) u_ja_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (restart),
        .raw     (JA[7:4]),
        .level   (ja_level),
        .toggled (ja_toggled)
    );

    assign btn_rise = btn_level & btn_toggled;

    act_t a_act, b_act;

    always_comb begin
        a_act = ACT_NONE;
        if      (btn_rise[BTN_U]) a_act = ACT_UP;
        else if (btn_rise[BTN_D]) a_act = ACT_DOWN;
        else if (btn_rise[BTN_L]) a_act = ACT_LEFT;
        else if (btn_rise[BTN_R]) a_act = ACT_RIGHT;
        else if (btn_rise[BTN_S]) a_act = ACT_BOMB;
    end

    assign b_act = (|ja_toggled) ? ja_decode(ja_level) : ACT_NONE;

    // ---------------- game state ----------------
    coord_t  a_x, a_y, b_x, b_y;
    health_t a_health, b_health;

    logic    a_bomb_active, b_bomb_active;
    coord_t  a_bomb_x, a_bomb_y, b_bomb_x, b_bomb_y;
    logic [FW-1:0] a_fuse, b_fuse;
    logic    a_boom, b_boom;

    game_state_t state, state_next;
    logic        play_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       state <= ST_PLAY;
        else if (restart) state <= ST_PLAY;
        else              state <= state_next;
    end

    // play_en also looks at the health registers so the cycle in which a
    // health hits zero already blocks input.
    always_comb begin
        state_next = state;
        play_en    = 1'b0;
        case (state)
            ST_PLAY: begin
                if (a_health == '0 || b_health == '0) state_next = ST_OVER;
                else                                  play_en    = 1'b1;
            end
            ST_OVER: state_next = ST_OVER;
            default: state_next = ST_PLAY;
        endcase
    end

    cell_t a_next, b_next;
    logic  a_move, b_move, a_drop, b_drop;

    assign a_next = step(a_x, a_y, a_act);
    assign b_next = step(b_x, b_y, b_act);

    assign a_move = play_en && a_next.ok && !is_pillar(a_next.x, a_next.y)
                    && !(a_next.x == b_x && a_next.y == b_y);
    // When both players step into the same free cell, A wins
    assign b_move = play_en && b_next.ok && !is_pillar(b_next.x, b_next.y)
                    && !(b_next.x == a_x && b_next.y == a_y)
                    && !(a_move && a_next.x == b_next.x && a_next.y == b_next.y);

    assign a_drop = play_en && (a_act == ACT_BOMB) && !a_bomb_active;
    assign b_drop = play_en && (b_act == ACT_BOMB) && !b_bomb_active;

    assign a_boom = a_bomb_active && (a_fuse == FW'(FUSE_CYCLES - 1));
    assign b_boom = b_bomb_active && (b_fuse == FW'(FUSE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || restart) begin
            a_x <= 3'd0;  a_y <= 3'd0;
            b_x <= 3'd1;  b_y <= 3'd0;
        end else begin
            if (a_move) begin a_x <= a_next.x; a_y <= a_next.y; end
            if (b_move) begin b_x <= b_next.x; b_y <= b_next.y; end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || restart) begin
            a_bomb_active <= 1'b0;  a_bomb_x <= '0;  a_bomb_y <= '0;  a_fuse <= '0;
            b_bomb_active <= 1'b0;  b_bomb_x <= '0;  b_bomb_y <= '0;  b_fuse <= '0;
        end else begin
            if (a_drop) begin
                a_bomb_active <= 1'b1;  a_bomb_x <= a_x;  a_bomb_y <= a_y;  a_fuse <= '0;
            end else if (a_boom) begin
                a_bomb_active <= 1'b0;  a_fuse <= '0;
            end else if (a_bomb_active) begin
                a_fuse <= a_fuse + 1'b1;
            end
            if (b_drop) begin
                b_bomb_active <= 1'b1;  b_bomb_x <= b_x;  b_bomb_y <= b_y;  b_fuse <= '0;
            end else if (b_boom) begin
                b_bomb_active <= 1'b0;  b_fuse <= '0;
            end else if (b_bomb_active) begin
                b_fuse <= b_fuse + 1'b1;
            end
        end
    end

    // A bomb only ever hurts its owner's opponent
    logic a_hit, b_hit;
    assign a_hit = b_boom && in_blast(b_bomb_x, b_bomb_y, a_x, a_y);
    assign b_hit = a_boom && in_blast(a_bomb_x, a_bomb_y, b_x, b_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || restart) begin
            a_health <= health_t'(HEALTH_INIT);
            b_health <= health_t'(HEALTH_INIT);
        end else begin
            if (a_hit && a_health != '0) a_health <= a_health - 4'd1;
            if (b_hit && b_health != '0) b_health <= b_health - 4'd1;
        end
    end

    // ---------------- seven-segment scan ----------------
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || restart) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
        end else if (refresh_cnt == RW'(REFRESH - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign an = ~(4'b0001 << scan_idx);

    always_comb begin
        seg = 8'hFF;
        case (scan_idx)
            2'd0:    seg = hex7(b_health);
            2'd3:    seg = hex7(a_health);
            default: seg = 8'hFF;
        endcase
    end

    // ---------------- VGA sync ----------------
    logic [1:0] pix_div;
    logic [9:0] h_cnt, v_cnt;
    logic       pix_tick;

    assign pix_tick = (pix_div == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || restart) begin
            pix_div <= 2'd0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            pix_div <= pix_div + 2'd1;
            if (pix_tick) begin
                if (h_cnt == H_TOTAL - 10'd1) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
            hsync <= !(h_cnt >= H_SYNC_START && h_cnt <= H_SYNC_END);
            vsync <= !(v_cnt >= V_SYNC_START && v_cnt <= V_SYNC_END);
        end
    end

endmodule

// File: tb/tb_bomberman.sv
// tb/tb_bomberman.sv - scoreboard testbench for the bomberman core
module tb_bomberman;

    localparam int BP = 20;

    localparam int K_AX = 0, K_AY = 1, K_BX = 2, K_BY = 3, K_HA = 4, K_HB = 5;
    localparam int K_AN_NOW = 6, K_AN_NEXT = 7, K_HS = 8, K_VS = 9;
    localparam int K_BOOMA = 10, K_BOOMB = 11, K_HPER = 12, K_HLOW = 13;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       btnU, btnD, btnL, btnR, btnS;
    logic [7:0] JA;
    logic [7:0] seg;
    logic [3:0] an;
    logic       hsync, vsync;

    bomberman #(
        .BOMB_PERIOD (BP),
        .FUSE_UNITS  (2),
        .DEBOUNCE    (4),
        .HEALTH_INIT (3),
        .REFRESH     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .btnU  (btnU),
        .btnD  (btnD),
        .btnL  (btnL),
        .btnR  (btnR),
        .btnS  (btnS),
        .JA    (JA),
        .seg   (seg),
        .an    (an),
        .hsync (hsync),
        .vsync (vsync)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int a_booms = 0, b_booms = 0;
    int a_mark  = 0, b_mark  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut.a_boom) a_booms = a_booms + 1;
        if (dut.b_boom) b_booms = b_booms + 1;
    end

    string tag_q[$];
    int    kind_q[$];
    int    val_q[$];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int seg_of(input int d);
        case (d)
            0: return 'hC0;
            1: return 'hF9;
            2: return 'hA4;
            3: return 'hB0;
            default: return 'hFF;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int kind, input int val);
        tag_q.push_back(tag);
        kind_q.push_back(kind);
        val_q.push_back(val);
    endtask

    task automatic expect_pos(input string p, input int ax, input int ay, input int bx, input int by);
        push_exp({p, "_ax"}, K_AX, ax);
        push_exp({p, "_ay"}, K_AY, ay);
        push_exp({p, "_bx"}, K_BX, bx);
        push_exp({p, "_by"}, K_BY, by);
    endtask

    task automatic expect_health(input string p, input int ha, input int hb);
        push_exp({p, "_ha"}, K_HA, seg_of(ha));
        push_exp({p, "_hb"}, K_HB, seg_of(hb));
    endtask

    task automatic read_seg(input int idx, output int v);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        v = -1;
        for (int i = 0; i < 200; i++) begin
            if (an === want) begin
                v = int'(seg);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_hs(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (hsync === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic observe(input int kind, output int v);
        bit o1, o2, o3, o4;
        int t0;
        logic [3:0] prev;
        v = -1;
        case (kind)
            K_AX:     v = int'(dut.a_x);
            K_AY:     v = int'(dut.a_y);
            K_BX:     v = int'(dut.b_x);
            K_BY:     v = int'(dut.b_y);
            K_HA:     read_seg(3, v);
            K_HB:     read_seg(0, v);
            K_AN_NOW: v = int'(an);
            K_AN_NEXT: begin
                prev = an;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (an !== prev) begin
                        v = int'(an);
                        break;
                    end
                end
            end
            K_HS:     v = int'(hsync);
            K_VS:     v = int'(vsync);
            K_BOOMA:  v = a_booms - a_mark;
            K_BOOMB:  v = b_booms - b_mark;
            K_HPER: begin
                wait_hs(1'b1, o1); wait_hs(1'b0, o2);
                t0 = cyc;
                wait_hs(1'b1, o3); wait_hs(1'b0, o4);
                v = (o1 && o2 && o3 && o4) ? cyc - t0 : -1;
            end
            K_HLOW: begin
                wait_hs(1'b1, o1); wait_hs(1'b0, o2);
                t0 = cyc;
                wait_hs(1'b1, o3);
                v = (o1 && o2 && o3) ? cyc - t0 : -1;
            end
            default: v = -1;
        endcase
    endtask

    task automatic drain();
        string t;
        int k, e, v;
        while (kind_q.size() > 0) begin
            t = tag_q.pop_front();
            k = kind_q.pop_front();
            e = val_q.pop_front();
            observe(k, v);
            check(t, v, e);
        end
    endtask

    task automatic mark_booms();
        a_mark = a_booms;
        b_mark = b_booms;
    endtask

    task automatic press_a(input int b);
        case (b)
            0: btnU = 1'b1;
            1: btnD = 1'b1;
            2: btnL = 1'b1;
            3: btnR = 1'b1;
            default: btnS = 1'b1;
        endcase
        repeat (14) @(negedge clk);
        {btnU, btnD, btnL, btnR, btnS} = 5'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_b(input logic [3:0] cmd);
        JA = {cmd, 4'b0000};
        repeat (20) @(negedge clk);
        JA = 8'h10;
        repeat (20) @(negedge clk);
    endtask

    task automatic restart_pulse();
        sw = 8'h80;
        repeat (BP) @(negedge clk);
        sw = 8'h00;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        sw = 8'h00;
        {btnU, btnD, btnL, btnR, btnS} = 5'b0;
        JA = 8'h10;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state and display scan
        push_exp("s1_an0", K_AN_NOW, 4'b1110);
        push_exp("s1_hs", K_HS, 1);
        push_exp("s1_vs", K_VS, 1);
        expect_pos("s1", 0, 0, 1, 0);
        push_exp("s1_an1", K_AN_NEXT, 4'b1101);
        push_exp("s1_an2", K_AN_NEXT, 4'b1011);
        push_exp("s1_an3", K_AN_NEXT, 4'b0111);
        expect_health("s1", 3, 3);
        drain();

        // 2: both drop a bomb on each other
        restart_pulse();
        mark_booms();
        press_a(4);
        JA = 8'hB0;
        repeat (2 * BP) @(negedge clk);
        JA = 8'h10;
        repeat (3 * BP) @(negedge clk);
        push_exp("s2_boom_a", K_BOOMA, 1);
        push_exp("s2_boom_b", K_BOOMB, 1);
        expect_health("s2", 2, 2);
        drain();

        // 3: moves with pillar block, then a bomb out of reach of B
        press_a(1); expect_pos("s3_d1", 0, 1, 1, 0); drain();
        press_a(1); expect_pos("s3_d2", 0, 2, 1, 0); drain();
        press_a(3); expect_pos("s3_r", 1, 2, 1, 0); drain();
        press_a(0); expect_pos("s3_u", 1, 2, 1, 0); drain();
        mark_booms();
        press_a(4);
        repeat (3 * BP) @(negedge clk);
        push_exp("s3_boom_a", K_BOOMA, 1);
        expect_health("s3", 2, 2);
        drain();

        // 4: grid edge and player collision
        restart_pulse();
        expect_health("s4_rst", 3, 3);
        drain();
        press_a(2); press_a(0);
        expect_pos("s4_a", 0, 0, 1, 0); drain();
        send_b(4'b0100); expect_pos("s4_bl", 0, 0, 1, 0); drain();
        send_b(4'b0101); expect_pos("s4_br", 0, 0, 2, 0); drain();
        send_b(4'b0010); expect_pos("s4_bu", 0, 0, 2, 0); drain();

        // 5: second drop while own bomb is live is ignored
        send_b(4'b0100); expect_pos("s5_bl", 0, 0, 1, 0); drain();
        mark_booms();
        press_a(4);
        press_a(4);
        repeat (3 * BP) @(negedge clk);
        push_exp("s5_boom_a", K_BOOMA, 1);
        expect_health("s5", 3, 2);
        drain();

        // 6: kill B, then everything is frozen until restart
        press_a(1);
        send_b(4'b0100);
        expect_pos("s6_pre", 0, 1, 0, 0); drain();
        press_a(4); repeat (50) @(negedge clk);
        press_a(4); repeat (50) @(negedge clk);
        expect_health("s6_dead", 3, 0);
        drain();
        mark_booms();
        send_b(4'b0101);
        press_a(1);
        expect_pos("s6_frozen", 0, 1, 0, 0); drain();
        JA = 8'hB0;
        repeat (20) @(negedge clk);
        JA = 8'h10;
        repeat (3 * BP) @(negedge clk);
        press_a(4);
        repeat (3 * BP) @(negedge clk);
        push_exp("s6_boom_a", K_BOOMA, 0);
        push_exp("s6_boom_b", K_BOOMB, 0);
        expect_health("s6_over", 3, 0);
        drain();

        restart_pulse();
        push_exp("s6_an0", K_AN_NOW, 4'b1110);
        push_exp("s6_hs", K_HS, 1);
        push_exp("s6_vs", K_VS, 1);
        expect_pos("s6_rst", 0, 0, 1, 0);
        expect_health("s6_rst", 3, 3);
        push_exp("s6_hper", K_HPER, 3200);
        push_exp("s6_hlow", K_HLOW, 384);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
